// File: rtl/dvp_pixel_packer.sv
// DVP camera capture: pairs 8-bit bytes into RGB565 pixels, keeps one frame in SKIP+1,
// and bounds each kept frame to H_DISP x V_DISP while flagging malformed lines.
module dvp_pixel_packer #(
    parameter int H_DISP = 640,
    parameter int V_DISP = 480,
    parameter int SKIP   = 1,
    parameter int VS_POL = 1
) (
    input  logic        video_clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        video_de,
    output logic [15:0] video_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        line_err,
    output logic [10:0] line_cnt,
    output logic [15:0] frame_cnt
);

    localparam int PW = $clog2(H_DISP + 1);
    localparam int SW = (SKIP == 0) ? 1 : $clog2(SKIP + 1);

    localparam logic [PW-1:0] H_MAX    = PW'(H_DISP);
    localparam logic [10:0]   V_MAX    = 11'(V_DISP);
    localparam logic [SW-1:0] SKIP_MAX = SW'(SKIP);
    localparam logic          VS_ACT   = (VS_POL != 0);

    localparam logic [1:0] ST_WAIT_VS = 2'd0;
    localparam logic [1:0] ST_IDLE_VS = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;
    localparam logic [1:0] ST_DROP    = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] skip_idx;
    logic          vsync_p0, vsync_p1;
    logic          href_p0, href_p1;
    logic [7:0]    data_p0;
    logic [7:0]    hi_byte_p1;
    logic          in_line, tgl, ovf, line_sup;
    logic [PW-1:0] pix_cnt;

    logic vs_act, href_rise, href_fall;
    logic act_byte, take_hi, pix_fire;

    function automatic logic [10:0] sat_inc_line(input logic [10:0] v);
        return (v >= V_MAX) ? v : v + 11'd1;
    endfunction

    function automatic logic [SW-1:0] wrap_inc_skip(input logic [SW-1:0] v);
        return (v >= SKIP_MAX) ? '0 : v + SW'(1);
    endfunction

    // ---- stage p0: pin registers; p1 holds the previous sample for edge detection
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_p0 <= ~VS_ACT;
            vsync_p1 <= ~VS_ACT;
            href_p0  <= 1'b0;
            href_p1  <= 1'b0;
        end else begin
            vsync_p0 <= cam_vsync;
            vsync_p1 <= vsync_p0;
            href_p0  <= cam_href;
            href_p1  <= href_p0;
        end
    end

    always_ff @(posedge video_clk) begin
        data_p0 <= cam_data;
    end

    assign vs_act    = (vsync_p0 == VS_ACT);
    assign href_rise = href_p0 & ~href_p1;
    assign href_fall = ~href_p0 & href_p1;

    // A rising href always opens a line with the high byte; later bytes alternate.
    assign act_byte = (state == ST_ACTIVE) && !vs_act && (href_rise || (in_line && href_p0));
    assign take_hi  = act_byte && (href_rise || !tgl);
    assign pix_fire = act_byte && !href_rise && tgl && !line_sup && (pix_cnt < H_MAX);

    // ---- stage p1: pixel assembly and frame/line control
    always_ff @(posedge video_clk) begin
        if (take_hi)
            hi_byte_p1 <= data_p0;
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n)
            video_data <= 16'h0000;
        else if (pix_fire)
            video_data <= {hi_byte_p1, data_p0};
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_WAIT_VS;
            skip_idx    <= '0;
            video_de    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            line_cnt    <= 11'd0;
            frame_cnt   <= 16'd0;
            in_line     <= 1'b0;
            tgl         <= 1'b0;
            ovf         <= 1'b0;
            line_sup    <= 1'b0;
            pix_cnt     <= '0;
        end else begin
            video_de    <= pix_fire;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            case (state)
                ST_WAIT_VS: begin
                    if (vs_act)
                        state <= ST_IDLE_VS;
                end
                ST_IDLE_VS: begin
                    if (!vs_act) begin
                        if (skip_idx == '0) begin
                            state       <= ST_ACTIVE;
                            frame_start <= 1'b1;
                            line_cnt    <= 11'd0;
                        end else begin
                            state <= ST_DROP;
                        end
                        skip_idx <= wrap_inc_skip(skip_idx);
                        in_line  <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (vs_act)
                        state <= ST_IDLE_VS;
                end
                ST_ACTIVE: begin
                    if (vs_act) begin
                        // A line still open at frame end is aborted, not counted.
                        state      <= ST_IDLE_VS;
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 16'd1;
                        line_err   <= in_line;
                        in_line    <= 1'b0;
                    end else if (href_rise) begin
                        in_line  <= 1'b1;
                        tgl      <= 1'b1;
                        ovf      <= 1'b0;
                        pix_cnt  <= '0;
                        line_sup <= (line_cnt >= V_MAX);
                    end else if (in_line && href_p0) begin
                        tgl <= ~tgl;
                        if (pix_fire)
                            pix_cnt <= pix_cnt + PW'(1);
                        else if (tgl)
                            ovf <= 1'b1;
                    end else if (in_line && href_fall) begin
                        in_line  <= 1'b0;
                        line_cnt <= sat_inc_line(line_cnt);
                        line_err <= tgl | ovf | line_sup | (pix_cnt != H_MAX);
                    end
                end
                default: state <= ST_WAIT_VS;
            endcase
        end
    end

endmodule

// File: doc/dvp_pixel_packer.md
# dvp_pixel_packer

Upstream video-domain stage of the UDP video path: captures an 8-bit DVP camera stream (vsync/href/byte data), pairs bytes into 16-bit RGB565 pixels, and keeps one frame out of every SKIP+1. Its `video_de`/`video_data` write the emitter's asynchronous FIFO directly; `frame_start`/`frame_done` tell the network side where frames begin and end. It also flags malformed lines and bounds every kept frame to H_DISP × V_DISP pixels.

## Interface
- `H_DISP`, 640, pixels per line emitted (2·H_DISP bytes expected per href)
- `V_DISP`, 480, lines per kept frame
- `SKIP`, 1, frames dropped after each kept frame (1 = keep every second frame)
- `VS_POL`, 1, active level of cam_vsync (1 = high during blanking pulse)
- `video_clk`  in  1  camera pixel clock, all logic rising-edge
- `rst_n`  in  1  reset; **one clock; reset is asynchronous and active-low**
- `cam_vsync`  in  1  frame sync
- `cam_href`  in  1  line valid
- `cam_data`  in  8  pixel byte, high byte first
- `video_de`  out  1  pixel valid, one cycle per pixel
- `video_data`  out  16  {first byte, second byte}
- `frame_start`  out  1  one-cycle pulse, kept frame begins
- `frame_done`  out  1  one-cycle pulse, kept frame ends
- `line_err`  out  1  one-cycle pulse, malformed line in kept frame
- `line_cnt`  out  11  lines completed in current kept frame
- `frame_cnt`  out  16  kept frames completed, wraps 0xFFFF→0

## Operation
- Input stage: cam_vsync/href/data registered once (r_*); all decisions use r_*. Vsync-active = (r_vsync == VS_POL).
- States: WAIT_VS (after reset, until a full vsync-active period ends), IDLE_VS (in vsync-active, between frames), ACTIVE (kept frame), DROP (skipped frame).
- WAIT_VS → IDLE_VS on first vsync-active. Partial frame in progress at reset is never emitted.
- IDLE_VS on vsync inactive edge: if skip_idx == 0 → ACTIVE, pulse frame_start, line_cnt←0; else → DROP. skip_idx increments mod SKIP+1 at each such edge (SKIP=0: every frame kept).
- ACTIVE/DROP → IDLE_VS on vsync-active edge. From ACTIVE: pulse frame_done, frame_cnt+1.
- Byte pairing (ACTIVE only): byte toggle cleared at each href rise; even byte latched as high half; odd byte completes pixel → video_de=1, video_data={hi,lo}, pix_cnt+1.
- Pixels beyond H_DISP on a line suppressed (no video_de).
- At href fall in ACTIVE: line_cnt+1 (saturates at V_DISP); line_err pulses if odd byte count or pix_cnt != H_DISP. Dangling odd byte is discarded.
- Lines with line_cnt == V_DISP at href rise: fully suppressed, line_err pulses at their href fall.
- Vsync-active edge while href high: line aborted, line not counted, line_err pulses same cycle as frame_done.
- href ignored during vsync-active, in DROP, WAIT_VS; no line_err there.

## Timing
- Reset values: video_de 0, video_data 0, frame_start 0, frame_done 0, line_err 0, line_cnt 0, frame_cnt 0, state WAIT_VS, skip_idx 0.
- video_de high in the cycle after the clock edge following the one at which the second byte was on cam_data (2-edge pin-to-output latency); video_data valid with video_de only, held otherwise.
- Continuous href at one byte/clock → video_de every second cycle; max throughput 1 pixel / 2 clocks.
- frame_start: 2 edges after vsync inactive on pins; frame_done/line_err likewise 2 edges after their pin event.
- line_cnt updates same cycle as line_err decision; frame_cnt updates with frame_done.
- Reset assertion mid-line: all outputs to reset values immediately (async); no further video_de until a complete vsync pulse is seen.

## Test plan
- H_DISP=4, V_DISP=3, SKIP=0: vsync pulse, 3 lines of bytes 0x01..0x08 → 12 video_de, first video_data 0x0102, frame_start then frame_done, line_cnt=3, frame_cnt=1, no line_err.
- SKIP=1: 4 consecutive frames → pixels only for frames 1 and 3, frame_cnt=2 at end, 2 frame_start pulses.
- Line of 9 bytes (H_DISP=4): 4 pixels, 9th byte dropped, line_err one pulse at href fall, line_cnt+1.
- Line of 12 bytes: only first 4 pixels emitted, line_err pulses; 4 lines in frame with V_DISP=3 → 4th line no video_de, line_err, line_cnt stays 3.
- Vsync asserted while href high after 2 pixels: frame_done and line_err same cycle, line_cnt unchanged.
- rst_n low mid-line, released mid-frame: no video_de until next vsync pulse completes; all outputs 0 during reset.
